new_alu_unit: RTL and testbench

- 32-bit registered ALU for the single-cycle computer datapath.
- Combines operand A with operand B, or with a zero-extended 16-bit immediate taken from B, according to a 4-bit opcode.
- Registers the 32-bit result, the NZCV flags and a separate carry output on the clock edge.
- Sits between the register file/immediate path and the writeback/flags logic.

---
 rtl/new_alu_unit.sv | 144 ++++++++++++++
 tb/tb_new_alu_unit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/new_alu_unit.sv
// new_alu_unit: registered 32-bit ALU with NZCV flags and a mirrored carry output.
// Operand B is either the register value or the zero-extended low 16 bits of b.
// Optional build macro NEWALU_SHIFT_EN adds LSL/LSR/ASR opcodes 0010/0011/0100.
// Without it, those codes decode as invalid (result 0, flags 0100).
module new_alu_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       ALUOp,
   input  logic             ior,
   output logic             carry,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       nzcv
);

   localparam logic [3:0] OP_PASSA = 4'b0000;
   localparam logic [3:0] OP_PASSB = 4'b0001;
   localparam logic [3:0] OP_ADDS  = 4'b0111;
   localparam logic [3:0] OP_ADDU  = 4'b1001;
   localparam logic [3:0] OP_SUB   = 4'b1010;
   localparam logic [3:0] OP_AND   = 4'b1011;
   localparam logic [3:0] OP_OR    = 4'b1100;
   localparam logic [3:0] OP_XOR   = 4'b1101;
   localparam logic [3:0] OP_NOT   = 4'b1110;
`ifdef NEWALU_SHIFT_EN
   localparam logic [3:0] OP_LSL   = 4'b0010;
   localparam logic [3:0] OP_LSR   = 4'b0011;
   localparam logic [3:0] OP_ASR   = 4'b0100;
`endif

   // Pack {N,Z,C,V}; N and Z always follow the result.
   function automatic logic [3:0] pack_flags(input logic [WIDTH-1:0] r,
                                             input logic c, input logic v);
      return {r[WIDTH-1], (r == '0), c, v};
   endfunction

   // Two's-complement overflow: operands of equal sign giving a result of the other sign.
   function automatic logic signed_ovf(input logic signed [WIDTH-1:0] x,
                                       input logic signed [WIDTH-1:0] y,
                                       input logic signed [WIDTH-1:0] r);
      return (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
   endfunction

   logic [WIDTH-1:0]        b_sel;
   logic [WIDTH:0]          sum_ext;
   logic [WIDTH:0]          diff_ext;
   logic signed [WIDTH-1:0] a_s;
   logic signed [WIDTH-1:0] b_s;
   logic signed [WIDTH-1:0] nb_s;
   logic [WIDTH-1:0]        res_p0;
   logic                    c_p0;
   logic                    v_p0;
   logic [3:0]              nzcv_p0;
`ifdef NEWALU_SHIFT_EN
   logic [4:0]              shamt;
   logic [WIDTH:0]          lsl_ext;
   logic [WIDTH:0]          lsr_ext;
   logic signed [WIDTH:0]   asr_ext;
`endif

   // Operand select and the shared adder/subtractor with an extra carry bit.
   always_comb begin
      b_sel    = ior ? {{(WIDTH-16){1'b0}}, b[15:0]} : b;
      sum_ext  = {1'b0, a} + {1'b0, b_sel};
      diff_ext = {1'b0, a} - {1'b0, b_sel};
      a_s      = $signed(a);
      b_s      = $signed(b_sel);
      nb_s     = ~b_s;
   end

`ifdef NEWALU_SHIFT_EN
   // Shifts carry one extra bit so the last bit shifted out lands next to the result.
   always_comb begin
      shamt   = b_sel[4:0];
      lsl_ext = {1'b0, a} << shamt;
      lsr_ext = {a, 1'b0} >> shamt;
      asr_ext = $signed({a, 1'b0}) >>> shamt;
   end
`endif

   // Opcode decode: next result plus C/V; invalid codes leave result 0, giving flags 0100.
   always_comb begin
      res_p0 = '0;
      c_p0   = 1'b0;
      v_p0   = 1'b0;
      case (ALUOp)
         OP_PASSA: res_p0 = a;
         OP_PASSB: res_p0 = b_sel;
         OP_ADDU: begin
            res_p0 = sum_ext[WIDTH-1:0];
            c_p0   = sum_ext[WIDTH];
         end
         OP_ADDS: begin
            res_p0 = sum_ext[WIDTH-1:0];
            c_p0   = sum_ext[WIDTH];
            v_p0   = signed_ovf(a_s, b_s, $signed(sum_ext[WIDTH-1:0]));
         end
         OP_SUB: begin
            // A - B overflows exactly when A + ~B would, judged on the operand signs.
            res_p0 = diff_ext[WIDTH-1:0];
            c_p0   = ~diff_ext[WIDTH];
            v_p0   = signed_ovf(a_s, nb_s, $signed(diff_ext[WIDTH-1:0]));
         end
         OP_AND:   res_p0 = a & b_sel;
         OP_OR:    res_p0 = a | b_sel;
         OP_XOR:   res_p0 = a ^ b_sel;
         OP_NOT:   res_p0 = ~a;
`ifdef NEWALU_SHIFT_EN
         OP_LSL: begin
            res_p0 = lsl_ext[WIDTH-1:0];
            c_p0   = lsl_ext[WIDTH];
         end
         OP_LSR: begin
            res_p0 = lsr_ext[WIDTH:1];
            c_p0   = lsr_ext[0];
         end
         OP_ASR: begin
            res_p0 = asr_ext[WIDTH:1];
            c_p0   = asr_ext[0];
         end
`endif
         default: res_p0 = '0;
      endcase
      nzcv_p0 = pack_flags(res_p0, c_p0, v_p0);
   end

   // ---- p0 -> output register ----
   // Output register; reset clears result and flags on the sampled edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         result <= '0;
         nzcv   <= 4'b0000;
      end else begin
         result <= res_p0;
         nzcv   <= nzcv_p0;
      end
   end

   assign carry = nzcv[1];

endmodule

// File: tb/tb_new_alu_unit.sv
// tb_new_alu_unit: directed vectors plus randomized stimulus against an arithmetic reference model.
module tb_new_alu_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] a;
   logic [31:0] b;
   logic [3:0]  ALUOp;
   logic        ior;
   logic        carry;
   logic [31:0] result;
   logic [3:0]  nzcv;

   int n_checks = 0;
   int n_fail   = 0;

   new_alu_unit #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .a(a), .b(b), .ALUOp(ALUOp), .ior(ior),
      .carry(carry), .result(result), .nzcv(nzcv)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Apply inputs, let one rising edge capture them, then sample 1 ns later.
   task automatic step(input logic rst, input logic [31:0] ta, input logic [31:0] tb,
                       input logic [3:0] op, input logic ti);
      reset = rst; a = ta; b = tb; ALUOp = op; ior = ti;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic [31:0] er, input logic [3:0] ef);
      check({tag, ".result"}, result, er);
      check({tag, ".nzcv"}, {28'h0, nzcv}, {28'h0, ef});
      check({tag, ".carry"}, {31'h0, carry}, {31'h0, ef[1]});
   endtask

   // Reference model in plain 64-bit integer arithmetic: returns {result, N, Z, C, V}.
   function automatic logic [35:0] ref_alu(input logic [31:0] ra, input logic [31:0] rb,
                                          input logic [3:0] op, input logic ri);
      logic [31:0] bp;
      logic [31:0] r;
      logic        c;
      logic        v;
      logic        ok;
      longint      ua, ub, s, sa, sb, ss;
      int          n;
      bp = ri ? (rb & 32'h0000FFFF) : rb;
      ua = longint'(ra);
      ub = longint'(bp);
      sa = longint'($signed(ra));
      sb = longint'($signed(bp));
      n  = int'(bp[4:0]);
      r = 32'h0; c = 1'b0; v = 1'b0; ok = 1'b1;
      case (op)
         4'b1001: begin s = ua + ub; r = s[31:0]; c = (s >= 64'h1_0000_0000); end
         4'b0111: begin
            s = ua + ub; r = s[31:0]; c = (s >= 64'h1_0000_0000);
            ss = sa + sb; v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
         end
         4'b1010: begin
            s = ua - ub; r = s[31:0]; c = (ua >= ub);
            ss = sa - sb; v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
         end
         4'b1011: r = ra & bp;
         4'b1100: r = ra | bp;
         4'b1101: r = ra ^ bp;
         4'b1110: r = ~ra;
         4'b0000: r = ra;
         4'b0001: r = bp;
`ifdef NEWALU_SHIFT_EN
         4'b0010: begin r = ra << n; c = (n == 0) ? 1'b0 : ra[32-n]; end
         4'b0011: begin r = ra >> n; c = (n == 0) ? 1'b0 : ra[n-1]; end
         4'b0100: begin r = $signed(ra) >>> n; c = (n == 0) ? 1'b0 : ra[n-1]; end
`endif
         default: ok = 1'b0;
      endcase
      if (!ok) return {32'h0, 4'b0100};
      return {r, r[31], (r == 32'h0), c, v};
   endfunction

   logic [35:0] exp_v;
   logic [31:0] ra, rb;
   logic [3:0]  rop;
   logic        ri, rr;

   initial begin
      // Reset with arbitrary inputs held for two cycles.
      step(1'b1, 32'hDEADBEEF, 32'h12345678, 4'b1001, 1'b0);
      expect_out("rst0", 32'h0, 4'b0000);
      step(1'b1, 32'hFFFFFFFF, 32'h00000001, 4'b0111, 1'b1);
      expect_out("rst1", 32'h0, 4'b0000);

      // Unsigned arithmetic and logic on a=0000FFFF, b=0.
      step(1'b0, 32'h0000FFFF, 32'h0, 4'b1001, 1'b0); expect_out("addu", 32'h0000FFFF, 4'b0000);
      step(1'b0, 32'h0000FFFF, 32'h0, 4'b1010, 1'b0); expect_out("sub0", 32'h0000FFFF, 4'b0010);
      step(1'b0, 32'h0000FFFF, 32'h0, 4'b1011, 1'b0); expect_out("and0", 32'h00000000, 4'b0100);
      step(1'b0, 32'h0000FFFF, 32'h0, 4'b1100, 1'b0); expect_out("or0",  32'h0000FFFF, 4'b0000);
      step(1'b0, 32'h0000FFFF, 32'h0, 4'b1101, 1'b0); expect_out("xor0", 32'h0000FFFF, 4'b0000);
      step(1'b0, 32'h0000FFFF, 32'h0, 4'b1110, 1'b0); expect_out("not0", 32'hFFFF0000, 4'b1000);

      // Signed add: zero wrap, negative with carry, positive overflow.
      step(1'b0, 32'hFFFFFFFF, 32'h00000001, 4'b0111, 1'b0); expect_out("adds_z", 32'h00000000, 4'b0110);
      step(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b0111, 1'b0); expect_out("adds_n", 32'hFFFFFFFE, 4'b1010);
      step(1'b0, 32'h7FFFFFFF, 32'h00000001, 4'b0111, 1'b0); expect_out("adds_v", 32'h80000000, 4'b1001);

      // Immediate select.
      step(1'b0, 32'hF0F0F0F0, 32'hFFFF00FF, 4'b1011, 1'b0); expect_out("imm_r",  32'hF0F000F0, 4'b1000);
      step(1'b0, 32'hF0F0F0F0, 32'hFFFF00FF, 4'b1011, 1'b1); expect_out("imm_i",  32'h000000F0, 4'b0000);
      step(1'b0, 32'hF0F0F0F0, 32'h0000FFFF, 4'b1011, 1'b1); expect_out("imm_i2", 32'h0000F0F0, 4'b0000);
      step(1'b0, 32'h00000000, 32'hABCD8001, 4'b0001, 1'b1); expect_out("passb_i", 32'h00008001, 4'b0000);

      // Subtract with borrow, signed subtract overflow, invalid opcode.
      step(1'b0, 32'h00000001, 32'h00000002, 4'b1010, 1'b0); expect_out("sub_bor", 32'hFFFFFFFF, 4'b1000);
      step(1'b0, 32'h80000000, 32'h00000001, 4'b1010, 1'b0); expect_out("sub_v",   32'h7FFFFFFF, 4'b0011);
      step(1'b0, 32'h12345678, 32'h9ABCDEF0, 4'b1111, 1'b0); expect_out("inv",     32'h00000000, 4'b0100);

`ifdef NEWALU_SHIFT_EN
      step(1'b0, 32'h80000001, 32'h00000001, 4'b0100, 1'b0); expect_out("asr1", 32'hC0000000, 4'b1010);
      step(1'b0, 32'h80000001, 32'h00000001, 4'b0010, 1'b0); expect_out("lsl1", 32'h00000002, 4'b0010);
      step(1'b0, 32'h80000001, 32'h00000000, 4'b0011, 1'b0); expect_out("lsr0", 32'h80000001, 4'b1000);
`else
      step(1'b0, 32'h80000001, 32'h00000001, 4'b0100, 1'b0); expect_out("asr_off", 32'h0, 4'b0100);
      step(1'b0, 32'h80000001, 32'h00000001, 4'b0010, 1'b0); expect_out("lsl_off", 32'h0, 4'b0100);
      step(1'b0, 32'h80000001, 32'h00000001, 4'b0011, 1'b0); expect_out("lsr_off", 32'h0, 4'b0100);
`endif

      // Mid-stream reset clears on the edge where it is sampled, then normal operation resumes.
      step(1'b0, 32'h7FFFFFFF, 32'h00000001, 4'b0111, 1'b0); expect_out("pre_rst", 32'h80000000, 4'b1001);
      step(1'b1, 32'h7FFFFFFF, 32'h00000001, 4'b0111, 1'b0); expect_out("mid_rst", 32'h0, 4'b0000);
      step(1'b0, 32'h00000005, 32'h00000003, 4'b1010, 1'b0); expect_out("post_rst", 32'h00000002, 4'b0010);

      // Randomized stimulus with occasional corner operands and sporadic resets.
      for (int i = 0; i < 500; i++) begin
         ra  = $urandom;
         rb  = $urandom;
         case ($urandom_range(0, 7))
            0: ra = 32'h7FFFFFFF;
            1: ra = 32'h80000000;
            2: rb = 32'hFFFFFFFF;
            3: rb = ra;
            default: ;
         endcase
         rop = 4'($urandom_range(0, 15));
         ri  = 1'($urandom_range(0, 1));
         rr  = ($urandom_range(0, 24) == 0);
         step(rr, ra, rb, rop, ri);
         exp_v = rr ? 36'h0 : ref_alu(ra, rb, rop, ri);
         expect_out($sformatf("rnd%0d_op%b", i, rop), exp_v[35:4], exp_v[3:0]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "simulation time limit reached");
   end

endmodule
